// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with load/clear, wrap or saturate, and enable prescaler.
// Latency: count_out/wrap_pulse update on the stepping edge; terminal is combinational; no backpressure.
module updown_mod_counter #(
  parameter int                WIDTH    = 8,
  parameter longint unsigned   MODULUS  = 256,
  parameter int                SATURATE = 0,
  parameter int                PRESCALE = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count_out,
  output logic             terminal,
  output logic             wrap_pulse
);

  // Top of range held one bit wider so MODULUS = 2**WIDTH compares without overflow.
  localparam logic [WIDTH:0]   MAX_C  = (WIDTH+1)'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] MAX_W  = MAX_C[WIDTH-1:0];

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             step;
  logic             at_max;
  logic             at_min;

  assign at_max = ({1'b0, count_q} == MAX_C);
  assign at_min = (count_q == '0);

  generate
    if (PRESCALE > 1) begin : g_prescale
      localparam int             PCW     = $clog2(PRESCALE);
      localparam logic [PCW-1:0] PC_LAST = PCW'(PRESCALE - 1);
      logic [PCW-1:0] pc_q, pc_d;

      always_comb begin
        pc_d = pc_q;
        step = 1'b0;
        if (clear || load) begin
          pc_d = '0;
        end else if (enable) begin
          if (pc_q == PC_LAST) begin
            pc_d = '0;
            step = 1'b1;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) pc_q <= '0;
        else          pc_q <= pc_d;
      end
    end else begin : g_no_prescale
      assign step = enable;
    end
  endgenerate

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = ({1'b0, load_value} > MAX_C) ? MAX_W : load_value;
    end else if (step) begin
      if (up_down) begin
        if (at_max) begin
          wrap_d  = 1'b1;
          count_d = (SATURATE != 0) ? count_q : '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (at_min) begin
          wrap_d  = 1'b1;
          count_d = (SATURATE != 0) ? count_q : MAX_W;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count_out  = count_q;
  assign wrap_pulse = wrap_q;
  assign terminal   = up_down ? at_max : at_min;

endmodule
